// File: rtl/jtag_debug_ocimem_ctrl.sv
// JTAG debug-RAM controller: decodes wrapper strobes into debug RAM ops, shares the RAM with a CPU Avalon slave.
// Debug write 2 cycles / read 3 cycles uncontended; CPU write 1 cycle, read 2; losers stall (waitrequest / REQ wait).
module jtag_debug_ocimem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

    state_t            state;
    logic              op_write;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [SW-1:0]     starve_cnt;
    logic              cpu_rd_pend;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q;

    logic              strobe_any;
    logic              cpu_req;
    logic              dbg_grant;
    logic              cpu_grant;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // The cycle after a CPU read grant belongs to the CPU (its data is on ram_q).
    assign cpu_req   = (cpu_read | cpu_write) & ~cpu_rd_pend;
    assign dbg_grant = (state == REQ) & ~cpu_rd_pend & (~cpu_req | (starve_cnt >= STARVE_MAX));
    assign cpu_grant = cpu_req & ~dbg_grant;
    assign ram_en    = ~reset & (dbg_grant | cpu_grant);

    always_comb begin
        ram_we    = cpu_write;
        ram_addr  = cpu_address;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
        if (dbg_grant) begin
            ram_we    = op_write;
            ram_addr  = mon_a_reg;
            ram_be    = 4'hF;
            ram_wdata = MonDReg;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_q <= mem[ram_addr];
            end
        end
    end

    assign cpu_readdata    = cpu_rd_pend ? ram_q : 32'h0;
    assign cpu_waitrequest = reset | ~(cpu_rd_pend | (cpu_grant & cpu_write));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_write      <= 1'b0;
            mon_a_reg     <= '0;
            starve_cnt    <= '0;
            cpu_rd_pend   <= 1'b0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            cpu_rd_pend <= cpu_grant & ~cpu_write;
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        mon_a_reg <= jdo[ADDR_W+17:18];
                        if (jdo[35]) monitor_error <= 1'b0;
                        if (jdo[34]) begin
                            op_write      <= 1'b0;
                            state         <= REQ;
                            monitor_ready <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        op_write      <= 1'b1;
                        state         <= REQ;
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        op_write      <= 1'b0;
                        state         <= REQ;
                        monitor_ready <= 1'b0;
                    end
                end
                REQ: begin
                    if (dbg_grant) begin
                        starve_cnt <= '0;
                        state      <= op_write ? DONE : RDATA;
                    end else if (cpu_grant) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    MonDReg <= ram_q;
                    state   <= DONE;
                end
                DONE: begin
                    mon_a_reg     <= mon_a_reg + 1'b1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if ((state != IDLE) && strobe_any) monitor_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtag_debug_ocimem_ctrl.sv
// Randomized bench for jtag_debug_ocimem_ctrl against a transaction-level memory/register model.
module tb_jtag_debug_ocimem_ctrl;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [37:0]   jdo = '0;
    logic          ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [31:0]   MonDReg;
    logic          monitor_ready, monitor_error;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0]   cpu_writedata = '0;
    logic [3:0]    cpu_byteenable = '0;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;

    jtag_debug_ocimem_ctrl #(.ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [256];
    logic [7:0]  mon_a;
    logic [31:0] mon_d;
    logic        err_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] rnd38();
        return 38'({$urandom, $urandom});
    endfunction

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input bit rd, input bit clr);
        logic [37:0] j;
        j = rnd38();
        j[25:18] = addr;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = rnd38();
        j[34:3] = data;
        return j;
    endfunction

    // Called at a negedge; pulses one strobe for exactly one rising edge.
    task automatic strobe(input int kind, input logic [37:0] j);
        jdo = j;
        ta_a = (kind == 0);
        ta_b = (kind == 1);
        tna_a = (kind == 2);
        @(negedge clk);
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!monitor_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic dbg_op(input string tag, input int kind, input logic [37:0] j, input int exp_lat);
        int lat;
        strobe(kind, j);
        wait_ready(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_mondreg"}, 64'(MonDReg), 64'(mon_d));
        chk({tag, "_err"}, 64'(monitor_error), 64'(err_m));
    endtask

    task automatic dbg_load(input string tag, input logic [7:0] addr, input bit rd, input bit clr);
        if (clr) err_m = 1'b0;
        if (rd) begin
            mon_d = mem_m[addr];
            mon_a = addr + 8'd1;
        end else begin
            mon_a = addr;
        end
        dbg_op(tag, 0, jdo_a(addr, rd, clr), rd ? 3 : 0);
    endtask

    task automatic dbg_write(input string tag, input logic [31:0] data);
        mem_m[mon_a] = data;
        mon_d = data;
        mon_a = mon_a + 8'd1;
        dbg_op(tag, 1, jdo_b(data), 2);
    endtask

    task automatic dbg_read(input string tag);
        mon_d = mem_m[mon_a];
        mon_a = mon_a + 8'd1;
        dbg_op(tag, 2, rnd38(), 3);
    endtask

    task automatic cpu_access(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] be, output int waits, output logic [31:0] rd);
        cpu_address = addr; cpu_writedata = data; cpu_byteenable = be;
        cpu_write = wr; cpu_read = ~wr;
        waits = 0;
        #1;
        while (cpu_waitrequest && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        rd = cpu_readdata;
        @(negedge clk);
        cpu_write = 1'b0; cpu_read = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        int w;
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[addr][8*b +: 8] = data[8*b +: 8];
        cpu_access(1'b1, addr, data, be, w, r);
        chk("cpu_wr_waits", 64'(w), 64'd0);
    endtask

    task automatic cpu_rd(input string tag, input logic [7:0] addr);
        int w;
        logic [31:0] r;
        cpu_access(1'b0, addr, 32'h0, 4'hF, w, r);
        chk({tag, "_waits"}, 64'(w), 64'd1);
        chk({tag, "_data"}, 64'(r), 64'(mem_m[addr]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idx, first_w, nwait;
        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_waitreq", 64'(cpu_waitrequest), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(monitor_ready), 64'd1);
        chk("rst_error", 64'(monitor_error), 64'd0);
        chk("rst_mondreg", 64'(MonDReg), 64'd0);
        chk("rst_readdata", 64'(cpu_readdata), 64'd0);
        mon_a = 8'h00; mon_d = 32'h0; err_m = 1'b0;

        // Fill RAM from the CPU side so every later read has a known value
        for (int a = 0; a < 256; a++) cpu_wr(8'(a), $urandom, 4'hF);

        // Debug write, then read back, MonAReg increment
        dbg_load("t1_load", 8'h10, 1'b0, 1'b0);
        dbg_write("t1_write", 32'hDEADBEEF);
        dbg_read("t1_next");
        dbg_load("t2_rd", 8'h10, 1'b1, 1'b0);
        chk("t2_data", 64'(MonDReg), 64'hDEADBEEF);
        dbg_read("t2_next");

        // Address wrap
        dbg_load("t3_load", 8'hFF, 1'b0, 1'b0);
        dbg_read("t3_ff");
        dbg_read("t3_wrap");

        // Strobe while busy is ignored and flags error; clear via ocimem_a
        mon_d = mem_m[mon_a];
        mon_a = mon_a + 8'd1;
        err_m = 1'b1;
        strobe(2, rnd38());
        strobe(1, jdo_b(32'h12345678));
        wait_ready(lat);
        chk("t4_lat", 64'(lat), 64'd2);
        chk("t4_mondreg", 64'(MonDReg), 64'(mon_d));
        chk("t4_err", 64'(monitor_error), 64'd1);
        dbg_load("t4_clr", 8'h30, 1'b0, 1'b1);

        // Starvation: CPU hammers writes, debug write wins on the 5th REQ cycle
        dbg_load("t5_load", 8'h41, 1'b0, 1'b0);
        cpu_address = 8'h40; cpu_writedata = 32'hC0FFEE01; cpu_byteenable = 4'hF; cpu_write = 1'b1;
        mem_m[8'h40] = 32'hC0FFEE01;
        mem_m[8'h41] = 32'h5A5A1234;
        mon_d = 32'h5A5A1234;
        mon_a = 8'h42;
        strobe(1, jdo_b(32'h5A5A1234));
        idx = 0; first_w = 0; nwait = 0;
        while (!monitor_ready && idx < 50) begin
            idx++;
            #1;
            if (cpu_waitrequest) begin
                nwait++;
                if (first_w == 0) first_w = idx;
            end
            @(negedge clk);
        end
        cpu_write = 1'b0;
        chk("t5_lat", 64'(idx), 64'd6);
        chk("t5_first_wait", 64'(first_w), 64'd5);
        chk("t5_nwait", 64'(nwait), 64'd1);
        chk("t5_mondreg", 64'(MonDReg), 64'(mon_d));
        dbg_read("t5_next");

        // Reset during REQ of a debug write
        dbg_load("t6_load", 8'h20, 1'b0, 1'b0);
        strobe(1, jdo_b(32'hBAD0BAD0));
        reset = 1'b1;
        #1;
        chk("t6_waitreq", 64'(cpu_waitrequest), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        mon_a = 8'h00; mon_d = 32'h0; err_m = 1'b0;
        chk("t6_ready", 64'(monitor_ready), 64'd1);
        chk("t6_mondreg", 64'(MonDReg), 64'd0);
        chk("t6_error", 64'(monitor_error), 64'd0);
        dbg_read("t6_addr0");
        cpu_rd("t6_ram20", 8'h20);

        // Randomized mix of debug commands and CPU accesses
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: dbg_load("r_load", 8'($urandom), 1'($urandom), 1'b0);
                1: dbg_write("r_write", $urandom);
                2: dbg_read("r_read");
                3: cpu_wr(8'($urandom), $urandom, 4'($urandom));
                default: cpu_rd("r_cpu_rd", 8'($urandom));
            endcase
        end

        // Whole-RAM sweep against the model
        for (int a = 0; a < 256; a++) cpu_rd("sweep", 8'(a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
